delay_line_ctrl: RTL
====================

// Module: delay_line_ctrl
// PURPOSE
//  Sequences the 512x8 dual-port sample RAM as a circular delay line for the signal generator.
//  - Each accepted input sample is written at wr_ptr.
//  - In the same cycle, the sample at wr_ptr-delay is read.
//  - The delayed sample is presented one cycle later.
//  - Sits between the sample source (sine LUT/counter path) and the output/DAC stage.
//  - Owns every control and address input of the RAM; the RAM is instantiated beside it at top level.
// PARAMETERS
//  ADDRESS_WIDTH  9  RAM address width; delay line depth = 2**ADDRESS_WIDTH
//  DATA_WIDTH     8  sample width
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  en           in   1   run enable; 0 = idle, pointer held
//  delay        in   AW  requested delay in samples, 0..2**AW-1
//  in_valid     in   1   input sample strobe
//  in_data      in   DW  input sample
//  out_valid    out  1   delayed sample strobe
//  out_data     out  DW  delayed sample
//  filled       out  1   1 once delay_q samples have been written since last (re)fill
//  ram_wr_en    out  1   RAM write enable
//  ram_wr_addr  out  AW  RAM write address
//  ram_din      out  DW  RAM write data
//  ram_rd_en    out  1   RAM read enable
//  ram_rd_addr  out  AW  RAM read address
//  ram_dout     in   DW  RAM read data (registered in RAM, valid 1 cycle after ram_rd_en)
// BEHAVIOUR
//  Reset values
//  - Reset is async on rst_n low.
//  - Held at reset: state=IDLE, wr_ptr=0, fill_cnt=0, delay_q=0, out_valid=0, out_data=0, filled=0.
//  - The ram_* outputs are 0 during reset.
//  State machine: IDLE, FILL, RUN
//  - IDLE -> FILL when en=1; latches delay_q<=delay and clears fill_cnt.
//  - FILL -> RUN when an accepted sample makes fill_cnt==delay_q.
//  - delay=0 goes IDLE->RUN directly.
//  - Any state -> IDLE when en=0.
//  - FILL/RUN: if delay != delay_q, re-latch delay_q and clear fill_cnt; next state is FILL (RUN if delay=0).
//  - wr_ptr is never cleared except by reset.
//  Accept rule
//  - A sample is accepted when in_valid=1 and state is FILL or RUN (en=1 and delay==delay_q).
//  - A sample is not accepted in IDLE or in the cycle a delay change is detected; in those cycles it is dropped.
//  Accept cycle (combinational RAM outputs)
//  - ram_wr_en=1, ram_wr_addr=wr_ptr, ram_din=in_data.
//  - ram_rd_en=1, ram_rd_addr=(wr_ptr-delay_q) mod 2**AW (natural AW-bit wrap).
//  - wr_ptr<=wr_ptr+1 with wrap 511->0.
//  - fill_cnt increments, saturating at delay_q.
//  Latency
//  - out_valid=1 exactly 1 cycle after each accepted sample; otherwise out_valid=0.
//  - out_data holds its last value when out_valid=0.
//  Output data select
//  - out_data=0 if the sample was accepted in FILL: stale RAM contents are never emitted.
//  - delay_q=0: RAM read-during-write returns old data, so out_data=in_data via a 1-cycle bypass register.
//  - Otherwise out_data=ram_dout.
//  filled
//  - filled=1 in RUN, 0 otherwise.
//  - Registered; rises the cycle after the accept that completes the fill.
//  Boundary conditions
//  - Maximum delay 2**AW-1: read address = wr_ptr+1, the oldest sample.
//  - en drop mid-stream: an in-flight out_valid still completes next cycle; then no further accepts.
//  - Reset mid-operation: all state cleared immediately; RAM contents are undefined and masked by FILL.
// STRUCTURE
//  delay_line_pkg holds:
//  - typedef enum logic [1:0] {IDLE, FILL, RUN} dl_state_t;
//  - localparams DEPTH=2**ADDRESS_WIDTH and MAX_DELAY=DEPTH-1.
//  Single module, no sub-module; the RAM is a sibling instance wired at top level.
// TESTING (bench models the 1-cycle registered RAM)
//  1. Reset, en=1, delay=3, in_data 1,2,3,4,5,6 on consecutive cycles -> out_data 0,0,0,1,2,3; filled rises after 3rd accept.
//  2. delay=0, in_data 0xA5 then 0x5A -> out_data 0xA5, 0x5A each 1 cycle later; filled=1 from first cycle.
//  3. delay=511, stream 600 samples of value k mod 256 -> first 511 outputs 0; output 511 = 0; wr_ptr wraps 511->0 without glitch.
//  4. In RUN with delay=3, change delay to 5 -> that cycle's sample dropped; next 5 outputs 0; then samples delayed by 5.
//  5. en=0 for 4 cycles mid-stream with in_valid=1 -> no RAM writes, out_valid=0; on en=1 -> refill (3 zero outputs for delay=3).
//  6. Assert rst_n=0 between clock edges during RUN -> all outputs 0 immediately; after release state=IDLE, wr_ptr=0.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and sizing for the circular sample delay line controller.
package delay_line_pkg;

  localparam int DL_ADDRESS_WIDTH = 9;
  localparam int DL_DATA_WIDTH    = 8;
  localparam int DEPTH            = 2 ** DL_ADDRESS_WIDTH;
  localparam int MAX_DELAY        = DEPTH - 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} dl_state_t;

endpackage

// File: rtl/delay_line_ctrl.sv
// Drives a 1-cycle registered dual-port RAM as a circular delay line: write at wr_ptr,
// read at wr_ptr-delay_q in the same cycle, emit the delayed sample one cycle later.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DL_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DL_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     filled,
  output logic                     ram_wr_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output dl_state_t                state
);

  localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

  // in_valid is a strobe with no backpressure: a sample offered while not accepted is
  // dropped. out_valid pulses for exactly one cycle, one cycle after each accept.
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] delay_q;
  logic [ADDRESS_WIDTH-1:0] fill_cnt;
  logic                     active;
  logic                     delay_change;
  logic                     accept;
  logic                     sel_zero;
  logic                     sel_byp;
  logic [DATA_WIDTH-1:0]    byp_data;
  logic [DATA_WIDTH-1:0]    hold_data;

  assign active       = (state == FILL) || (state == RUN);
  assign delay_change = active && en && (delay != delay_q);
  assign accept       = active && en && in_valid && !delay_change;

  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_din     = '0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    if (accept) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = wr_ptr;
      ram_din     = in_data;
      ram_rd_en   = 1'b1;
      ram_rd_addr = wr_ptr - delay_q;
    end
  end

  // RAM data only exists in the out_valid cycle, so the selection is combinational
  // and hold_data keeps the last emitted value between strobes.
  always_comb begin
    out_data = hold_data;
    if (out_valid) begin
      if (sel_zero)     out_data = '0;
      else if (sel_byp) out_data = byp_data;
      else              out_data = ram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      delay_q   <= '0;
      out_valid <= 1'b0;
      filled    <= 1'b0;
      sel_zero  <= 1'b0;
      sel_byp   <= 1'b0;
      byp_data  <= '0;
      hold_data <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        sel_zero <= (state == FILL);
        sel_byp  <= (delay_q == '0);
        byp_data <= in_data;
      end
      if (out_valid) hold_data <= out_data;

      if (!en) begin
        state  <= IDLE;
        filled <= 1'b0;
      end else if ((state == IDLE) || delay_change) begin
        delay_q  <= delay;
        fill_cnt <= '0;
        if (delay == '0) begin
          state  <= RUN;
          filled <= 1'b1;
        end else begin
          state  <= FILL;
          filled <= 1'b0;
        end
      end else if (accept) begin
        wr_ptr <= wr_ptr + ONE;
        if (fill_cnt != delay_q) fill_cnt <= fill_cnt + ONE;
        if ((state == FILL) && ((fill_cnt + ONE) == delay_q)) begin
          state  <= RUN;
          filled <= 1'b1;
        end
      end
    end
  end

endmodule
